// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM states and control bundles.
// Pure declarations; no timing or flow-control behaviour of its own.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_hold;
    logic if_dwrite;
    logic id_ex_flush;
    logic ex_hold;
  } ctl_t;

  localparam int WAIT_W = 8;

  localparam ctl_t CTL_IDLE = '{pc_hold: 1'b0, if_dwrite: 1'b0, id_ex_flush: 1'b0, ex_hold: 1'b0};
  // Held in reset: both pipeline registers see bubbles, nothing is frozen.
  localparam ctl_t CTL_RST  = '{pc_hold: 1'b0, if_dwrite: 1'b1, id_ex_flush: 1'b1, ex_hold: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the stall controller (slave).
// Plain wires; the controller answers combinationally, no handshake.
interface pipe_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_useRs1;
  logic        id_useRs2;
  logic [4:0]  ex_rd;
  logic        ex_memRead;
  logic        ex_jump;
  logic        md_start;
  logic        md_done;
  logic        imem_ready;
  logic        pc_hold;
  logic        if_dWrite;
  logic        id_ex_flush;
  logic        ex_hold;
  logic        md_err;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_useRs1, id_useRs2, ex_rd, ex_memRead,
           ex_jump, md_start, md_done, imem_ready,
    input  pc_hold, if_dWrite, id_ex_flush, ex_hold, md_err, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_useRs1, id_useRs2, ex_rd, ex_memRead,
           ex_jump, md_start, md_done, imem_ready,
    output pc_hold, if_dWrite, id_ex_flush, ex_hold, md_err, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID source that depends on a load still in EX.
// Purely combinational; no backpressure.
module hazard_detect (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller (RUN/FLUSH/MD_WAIT); controls combinational, md_err/stall_cnt registered.
// No backpressure of its own: it is the source of pc_hold/ex_hold for the rest of the pipe.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              load_use;
  logic              md_err_nxt;
  ctl_t              ctl;

  hazard_detect u_hazard_detect (
    .rs1         (bus.id_rs1),
    .rs2         (bus.id_rs2),
    .use_rs1     (bus.id_useRs1),
    .use_rs2     (bus.id_useRs2),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_memRead),
    .load_use    (load_use)
  );

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    md_err_nxt = 1'b0;
    ctl        = CTL_IDLE;
    case (state)
      ST_RUN: begin
        if (bus.ex_jump) begin
          ctl.if_dwrite   = 1'b1;
          ctl.id_ex_flush = 1'b1;
          state_nxt       = ST_FLUSH;
        end else if (bus.md_start) begin
          state_nxt = ST_MD_WAIT;
          wait_nxt  = '0;
        end else if (load_use) begin
          ctl.pc_hold     = 1'b1;
          ctl.id_ex_flush = 1'b1;
        end else if (!bus.imem_ready) begin
          ctl.pc_hold   = 1'b1;
          ctl.if_dwrite = 1'b1;
        end
      end
      // The instruction fetched behind the redirect is still in flight; squash it too.
      ST_FLUSH: begin
        ctl.if_dwrite = 1'b1;
        state_nxt     = ST_RUN;
      end
      ST_MD_WAIT: begin
        if (bus.md_done) begin
          state_nxt = ST_RUN;
        end else begin
          ctl.pc_hold = 1'b1;
          ctl.ex_hold = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt  = ST_RUN;
            md_err_nxt = 1'b1;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (rst) ctl = CTL_RST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      wait_cnt      <= '0;
      bus.md_err    <= 1'b0;
      bus.stall_cnt <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      bus.md_err <= md_err_nxt;
      if (ctl.pc_hold && (bus.stall_cnt != 32'hFFFF_FFFF))
        bus.stall_cnt <= bus.stall_cnt + 32'd1;
    end
  end

  assign bus.pc_hold     = ctl.pc_hold;
  assign bus.if_dWrite   = ctl.if_dwrite;
  assign bus.id_ex_flush = ctl.id_ex_flush;
  assign bus.ex_hold     = ctl.ex_hold;

endmodule
